blake2_block_ctrl: RTL and testbench
====================================

// Module: blake2_block_ctrl
// PURPOSE
//  Message sequencer in front of the blake2 compression core. Accepts a message as a stream of W-bit
//  words (valid/ready), packs 16 words into a zero-padded block and tracks the byte count. Issues each
//  block to the core with first/last flags, waits for core completion, and returns the final hash.
//  Adds a watchdog that flags a core that never reports done.
// PARAMETERS
//  W        64   word width in bits (64 = blake2b, 32 = blake2s); bytes per word WB = W/8
//  R        12   core rounds; watchdog limit = R+4 cycles in WAIT
//  NB_W     4    width of data_bytes_i = $clog2(WB)+1
// PORTS
//  clk            in   1       clock
//  nreset         in   1       asynchronous active-low reset
//  start_i        in   1       begin new message; sampled only in IDLE
//  kk_i           in   8       key length; latched on accepted start_i
//  nn_i           in   8       hash length; latched on accepted start_i
//  data_valid_i   in   1       message word valid
//  data_ready_o   out  1       controller accepts a word this cycle
//  data_i         in   W       message word, byte 0 in bits [7:0]
//  data_last_i    in   1       word is the final word of the message
//  data_bytes_i   in   NB_W    valid bytes in final word (0..WB); ignored unless data_last_i
//  core_valid_o   out  1       one-cycle block issue pulse to core valid_i
//  core_first_o   out  1       block is first of message
//  core_last_o    out  1       block is final block
//  core_ll_o      out  64      bytes accepted so far, including current block
//  core_kk_o      out  8       latched kk
//  core_nn_o      out  8       latched nn
//  core_d_o       out  16*W    block; word k at bits [W*k +: W]
//  core_valid_i   in   1       core done pulse
//  core_h_i       in   8*W     core hash output
//  hash_valid_o   out  1       one-cycle pulse: hash_o valid
//  hash_o         out  8*W     captured hash of last block
//  busy_o         out  1       state != IDLE
//  error_o        out  1       sticky watchdog error
// BEHAVIOUR
//  - Reset: state IDLE; all outputs, word index, ll counter, block buffer, hash_o, error_o = 0.
//  - States: IDLE -> FILL on start_i (error_o cleared, first flag set, ll = 0, word idx = 0).
//    FILL: data_ready_o=1; each accepted word written at idx, idx++, ll += WB
//      (last word: ll += min(data_bytes_i, WB); bytes >= data_bytes_i zeroed).
//      -> ISSUE after 16th word or after data_last_i word. Unwritten words zero-filled.
//    ISSUE: core_valid_o=1 for exactly one cycle; core_last_o = message ended in this block. -> WAIT.
//    WAIT: core_d/first/last/ll/kk/nn outputs stable. On core_valid_i: if last -> DONE, else first
//      flag cleared, buffer zeroed, idx=0 -> FILL. Watchdog counts WAIT cycles; reaching R+4 without
//      core_valid_i -> error_o=1, -> IDLE.
//    DONE: hash_o <= core_h_i captured on the core_valid_i edge; hash_valid_o=1 one cycle; -> IDLE.
//  - data_ready_o=0 outside FILL; words offered then are not consumed. start_i outside IDLE ignored.
//  - Full final block: 16th word with data_last_i issues as last; no trailing empty block.
//  - Empty message: first word with data_last_i and data_bytes_i=0 -> all-zero block, ll=0, last=1.
//  - data_bytes_i=0 on a non-first last word: no bytes added, that word zero.
//  - ll counter wraps modulo 2^64.
//  - Issue-to-done latency is the core's; controller overhead: 1 cycle ISSUE + 1 cycle DONE.
//  - nreset asserted mid-message aborts immediately; no hash_valid_o for the aborted message.
// TESTING
//  - "abc" (W=64): one word 0x636261, bytes=3, last -> one block, first=last=1, ll=3, d word0=0x636261.
//  - 128 bytes, 16 words, last on 16th -> single block last=1, ll=128; no second core_valid_o.
//  - 129 bytes -> block1 first=1 last=0 ll=128; block2 first=0 last=1 ll=129, word0 = byte 128 only.
//  - Empty message -> zero block, ll=0, last=1; hash_valid_o one cycle after core_valid_i.
//  - Core never returns core_valid_i -> error_o=1 after R+4 WAIT cycles, IDLE; next start_i clears it.
//  - nreset low during WAIT -> IDLE, outputs 0; later core_valid_i pulse produces no hash_valid_o.

Source files
------------

// File: rtl/blake2_block_ctrl.sv
// blake2_block_ctrl: packs a W-bit message stream into 16-word blocks,
// sequences them through the compression core and returns the final hash.
module blake2_block_ctrl #(
    parameter int W    = 64,
    parameter int R    = 12,
    parameter int NB_W = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start_i,
    input  logic [7:0]        kk_i,
    input  logic [7:0]        nn_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [W-1:0]      data_i,
    input  logic              data_last_i,
    input  logic [NB_W-1:0]   data_bytes_i,
    output logic              core_valid_o,
    output logic              core_first_o,
    output logic              core_last_o,
    output logic [63:0]       core_ll_o,
    output logic [7:0]        core_kk_o,
    output logic [7:0]        core_nn_o,
    output logic [16*W-1:0]   core_d_o,
    input  logic              core_valid_i,
    input  logic [8*W-1:0]    core_h_i,
    output logic              hash_valid_o,
    output logic [8*W-1:0]    hash_o,
    output logic              busy_o,
    output logic              error_o
);

    localparam int WB  = W / 8;
    localparam int WDW = $clog2(R + 5);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [63:0]     ll_q, ll_d;
    logic [16*W-1:0] buf_q, buf_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [7:0]      kk_q, kk_d;
    logic [7:0]      nn_q, nn_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [8*W-1:0]  hash_q, hash_d;
    logic            err_q, err_d;

    logic [NB_W-1:0] nb;
    logic [W-1:0]    word_m;

    // final word: clamp byte count and zero everything past it
    always_comb begin
        nb = (data_bytes_i > NB_W'(WB)) ? NB_W'(WB) : data_bytes_i;
        word_m = '0;
        for (int b = 0; b < WB; b++) begin
            word_m[8*b +: 8] = (b < int'(nb)) ? data_i[8*b +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ll_d    = ll_q;
        buf_d   = buf_q;
        first_d = first_q;
        last_d  = last_q;
        kk_d    = kk_q;
        nn_d    = nn_q;
        wd_d    = wd_q;
        hash_d  = hash_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FILL;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    ll_d    = '0;
                    idx_d   = '0;
                    buf_d   = '0;
                    kk_d    = kk_i;
                    nn_d    = nn_i;
                end
            end
            S_FILL: begin
                if (data_valid_i) begin
                    idx_d = idx_q + 4'd1;
                    if (data_last_i) begin
                        buf_d[W*idx_q +: W] = word_m;
                        ll_d    = ll_q + 64'(nb);
                        last_d  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        buf_d[W*idx_q +: W] = data_i;
                        ll_d = ll_q + 64'(WB);
                        if (idx_q == 4'd15) begin
                            state_d = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (core_valid_i) begin
                    if (last_q) begin
                        hash_d  = core_h_i;
                        state_d = S_DONE;
                    end else begin
                        first_d = 1'b0;
                        buf_d   = '0;
                        idx_d   = '0;
                        state_d = S_FILL;
                    end
                end else if (wd_q == WDW'(R + 3)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ll_q    <= '0;
            buf_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            kk_q    <= '0;
            nn_q    <= '0;
            wd_q    <= '0;
            hash_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ll_q    <= ll_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            last_q  <= last_d;
            kk_q    <= kk_d;
            nn_q    <= nn_d;
            wd_q    <= wd_d;
            hash_q  <= hash_d;
            err_q   <= err_d;
        end
    end

    assign data_ready_o = (state_q == S_FILL);
    assign core_valid_o = (state_q == S_ISSUE);
    assign core_first_o = first_q;
    assign core_last_o  = last_q;
    assign core_ll_o    = ll_q;
    assign core_kk_o    = kk_q;
    assign core_nn_o    = nn_q;
    assign core_d_o     = buf_q;
    assign hash_valid_o = (state_q == S_DONE);
    assign hash_o       = hash_q;
    assign busy_o       = (state_q != S_IDLE);
    assign error_o      = err_q;

endmodule

// File: tb/tb_blake2_block_ctrl.sv
// Randomized scoreboard bench for blake2_block_ctrl: expected blocks and
// hashes are derived from the byte-level message and checked by monitors.
module tb_blake2_block_ctrl;

    localparam int W    = 64;
    localparam int R    = 12;
    localparam int NB_W = 4;

    logic              clk = 1'b0;
    logic              nreset;
    logic              start_i;
    logic [7:0]        kk_i;
    logic [7:0]        nn_i;
    logic              data_valid_i;
    logic              data_ready_o;
    logic [W-1:0]      data_i;
    logic              data_last_i;
    logic [NB_W-1:0]   data_bytes_i;
    logic              core_valid_o;
    logic              core_first_o;
    logic              core_last_o;
    logic [63:0]       core_ll_o;
    logic [7:0]        core_kk_o;
    logic [7:0]        core_nn_o;
    logic [16*W-1:0]   core_d_o;
    logic              core_valid_i;
    logic [8*W-1:0]    core_h_i;
    logic              hash_valid_o;
    logic [8*W-1:0]    hash_o;
    logic              busy_o;
    logic              error_o;

    blake2_block_ctrl #(.W(W), .R(R), .NB_W(NB_W)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .start_i      (start_i),
        .kk_i         (kk_i),
        .nn_i         (nn_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_i       (data_i),
        .data_last_i  (data_last_i),
        .data_bytes_i (data_bytes_i),
        .core_valid_o (core_valid_o),
        .core_first_o (core_first_o),
        .core_last_o  (core_last_o),
        .core_ll_o    (core_ll_o),
        .core_kk_o    (core_kk_o),
        .core_nn_o    (core_nn_o),
        .core_d_o     (core_d_o),
        .core_valid_i (core_valid_i),
        .core_h_i     (core_h_i),
        .hash_valid_o (hash_valid_o),
        .hash_o       (hash_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          first;
        bit          last;
        logic [63:0] ll;
        logic [7:0]  kk;
        logic [7:0]  nn;
        logic [1023:0] d;
    } blk_t;

    typedef struct {
        bit respond;
        bit push_hash;
        int lat;
    } rsp_t;

    typedef struct {
        logic [511:0] h;
        int           c;
    } hsh_t;

    blk_t         blk_q[$];
    rsp_t         rsp_q[$];
    hsh_t         hsh_q[$];
    byte unsigned msg[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // block monitor
    always @(negedge clk) begin
        if (nreset && core_valid_o) begin
            if (blk_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got core_valid_o=1 expected 0");
            end else begin
                blk_t e;
                e = blk_q.pop_front();
                chk("blk_first", 512'(core_first_o), 512'(e.first));
                chk("blk_last", 512'(core_last_o), 512'(e.last));
                chk("blk_ll", 512'(core_ll_o), 512'(e.ll));
                chk("blk_kk", 512'(core_kk_o), 512'(e.kk));
                chk("blk_nn", 512'(core_nn_o), 512'(e.nn));
                for (int k = 0; k < 16; k++) begin
                    chk($sformatf("blk_d_w%0d", k),
                        512'(core_d_o[64*k +: 64]), 512'(e.d[64*k +: 64]));
                end
            end
        end
    end

    // hash monitor
    always @(negedge clk) begin
        if (hash_valid_o) begin
            if (hsh_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hash: got hash_valid_o=1 expected 0");
            end else begin
                hsh_t e;
                e = hsh_q.pop_front();
                chk("hash", hash_o, e.h);
                chk("hash_lat", 512'(cyc), 512'(e.c + 1));
            end
        end
    end

    // core model: answers each issued block after a chosen latency
    initial begin
        rsp_t         r;
        logic [511:0] h;
        core_valid_i = 1'b0;
        core_h_i     = '0;
        forever begin
            @(negedge clk);
            if (nreset && core_valid_o && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                if (r.respond) begin
                    repeat (r.lat) @(posedge clk);
                    #1;
                    for (int q = 0; q < 16; q++) h[32*q +: 32] = $urandom;
                    core_h_i     = h;
                    core_valid_i = 1'b1;
                    if (r.push_hash) hsh_q.push_back('{h, cyc});
                    @(posedge clk);
                    #1;
                    core_valid_i = 1'b0;
                end
            end
        end
    end

    task automatic fill_rand(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy_o && g < 600);
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy_o=1 expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    // builds expectations from the byte stream, then drives the words
    task automatic send_msg(input bit tail0, input int lat,
                            input bit respond, input bit push_hash);
        int          len;
        int          nblk;
        int          nw;
        int          lastb;
        int          guard;
        bit          hs;
        blk_t        e;
        rsp_t        r;
        logic [7:0]  kk;
        logic [7:0]  nn;
        logic [63:0] w;
        len  = msg.size();
        kk   = 8'($urandom);
        nn   = 8'($urandom);
        nblk = (len == 0) ? 1 : (len + 127) / 128;
        for (int i = 0; i < nblk; i++) begin
            e.first = (i == 0);
            e.last  = (i == nblk - 1);
            e.ll    = 64'(((i + 1) * 128 < len) ? (i + 1) * 128 : len);
            e.kk    = kk;
            e.nn    = nn;
            e.d     = '0;
            for (int b = 0; b < 128; b++) begin
                if (i * 128 + b < len) e.d[8*b +: 8] = msg[i*128 + b];
            end
            blk_q.push_back(e);
            r.respond   = e.last ? respond : 1'b1;
            r.push_hash = e.last && push_hash;
            r.lat       = (e.last && lat > 0) ? lat : $urandom_range(1, 10);
            rsp_q.push_back(r);
        end
        start_i = 1'b1;
        kk_i    = kk;
        nn_i    = nn;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        nw    = (len == 0) ? 1 : (len + 7) / 8;
        lastb = (len == 0) ? 0 : len - 8 * (nw - 1);
        if (tail0) begin
            nw++;
            lastb = 0;
        end
        for (int j = 0; j < nw; j++) begin
            w = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) begin
                if (j * 8 + b < len) w[8*b +: 8] = msg[j*8 + b];
            end
            guard = 0;
            hs    = 1'b0;
            while (!hs && guard < 400) begin
                data_valid_i = ($urandom_range(0, 3) != 0);
                data_i       = data_valid_i ? w : {$urandom, $urandom};
                data_last_i  = (j == nw - 1);
                data_bytes_i = data_last_i ? NB_W'(lastb) : NB_W'($urandom);
                start_i      = ($urandom_range(0, 7) == 0);
                kk_i         = 8'($urandom);
                nn_i         = 8'($urandom);
                @(negedge clk);
                hs = data_valid_i && data_ready_o;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL word_timeout: got no handshake expected word %0d", j);
                break;
            end
        end
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        start_i      = 1'b0;
        if (respond && push_hash) wait_idle();
    endtask

    task automatic wait_issue();
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            seen = core_valid_o;
            n++;
        end
        chk("issue_seen", 512'(seen), 512'(1));
    endtask

    initial begin
        int n;
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        nreset       = 1'b0;
        start_i      = 1'b0;
        kk_i         = '0;
        nn_i         = '0;
        data_valid_i = 1'b0;
        data_i       = '0;
        data_last_i  = 1'b0;
        data_bytes_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 512'(busy_o), 512'(0));
        chk("rst_ready", 512'(data_ready_o), 512'(0));
        chk("rst_cvalid", 512'(core_valid_o), 512'(0));
        chk("rst_hvalid", 512'(hash_valid_o), 512'(0));
        chk("rst_err", 512'(error_o), 512'(0));
        chk("rst_ll", 512'(core_ll_o), 512'(0));
        chk("rst_d_zero", 512'(core_d_o == '0), 512'(1));
        chk("rst_hash", hash_o, 512'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 0, 1'b1, 1'b1);
        fill_rand(128);
        send_msg(1'b0, 0, 1'b1, 1'b1);
        fill_rand(129);
        send_msg(1'b0, 0, 1'b1, 1'b1);
        msg.delete();
        send_msg(1'b0, 0, 1'b1, 1'b1);
        fill_rand(24);
        send_msg(1'b1, 0, 1'b1, 1'b1);
        fill_rand(40);
        send_msg(1'b0, R + 4, 1'b1, 1'b1);
        repeat (8) begin
            fill_rand($urandom_range(0, 300));
            send_msg(1'b0, 0, 1'b1, 1'b1);
        end

        // silent core: watchdog fires after R+4 WAIT cycles
        fill_rand(5);
        send_msg(1'b0, 0, 1'b0, 1'b0);
        wait_issue();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!error_o && n < 40);
        chk("wd_cycles", 512'(n), 512'(R + 5));
        chk("wd_err", 512'(error_o), 512'(1));
        chk("wd_idle", 512'(busy_o), 512'(0));
        repeat (3) @(negedge clk);
        chk("wd_sticky", 512'(error_o), 512'(1));
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 0, 1'b1, 1'b1);
        chk("wd_cleared", 512'(error_o), 512'(0));

        // reset while waiting on the core
        fill_rand(20);
        send_msg(1'b0, 10, 1'b1, 1'b0);
        wait_issue();
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 512'(busy_o), 512'(0));
        chk("abort_ll", 512'(core_ll_o), 512'(0));
        chk("abort_d_zero", 512'(core_d_o == '0), 512'(1));
        chk("abort_first", 512'(core_first_o), 512'(0));
        chk("abort_hash", hash_o, 512'(0));
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_idle", 512'(busy_o), 512'(0));
        @(posedge clk);
        #1;
        fill_rand(50);
        send_msg(1'b0, 0, 1'b1, 1'b1);

        repeat (4) @(negedge clk);
        chk("blk_q_empty", 512'(blk_q.size()), 512'(0));
        chk("rsp_q_empty", 512'(rsp_q.size()), 512'(0));
        chk("hsh_q_empty", 512'(hsh_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
